cve2_register_file_mp: RTL and testbench

Parametrised flip-flop register file for cve2: a multi-read-port, dual-write-port register file with a per-register busy scoreboard. Write port 0 carries the in-order writeback. Write port 1 carries late or offloaded writeback (coprocessor / X-interface results). It sits in the ID stage in place of the single-write, two-read FF register file. It gives the decoder operand data plus busy status, so stalls on outstanding results can be raised without a separate scoreboard.

---
 rtl/cve2_register_file_mp.sv | 236 +++++++++++++++++++++++
 tb/tb_cve2_register_file_mp.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_register_file_mp.sv
// ---------------------------------------------------------------------------
// cve2_register_file_mp
//
// Flip-flop register file for the cve2 ID stage. It has a configurable number
// of read ports and two write ports. A per-register busy scoreboard lets the
// decoder stall on results that are still outstanding.
//
//   - Write port 0 carries the in-order writeback.
//   - Write port 1 carries late or offloaded writeback (coprocessor results).
//     A port-1 write to a register also releases that register's busy bit.
//
// Parameters
//   RV32E        : 1 gives 16 architectural registers, 0 gives 32.
//   DataWidth    : width of each register word.
//   WordZeroVal  : value of x0, of every register after reset, and of any
//                  out-of-range read.
//   NumReadPorts : number of read ports (1..4).
//   BypassEn     : 1 forwards same-cycle write data to the read ports.
//
// Ports
//   clk_i, rst_i         : clock; synchronous active-high reset.
//   raddr_i / rdata_o    : read addresses and combinational read data.
//   rbusy_o              : registered busy bit of each addressed register.
//   we_i/waddr_i/wdata_i : two write ports; port 0 wins on collision.
//   rsv_valid_i/rsv_addr_i/rsv_ready_o : reservation handshake that marks a
//                          register busy.
//   busy_o               : full scoreboard vector; bit 0 always reads 0.
//   wr_collision_o       : one-cycle pulse. It is set when both write ports
//                          hit the same non-zero register in the previous
//                          cycle.
// ---------------------------------------------------------------------------
module cve2_register_file_mp #(
  parameter bit                   RV32E        = 1'b0,
  parameter int unsigned          DataWidth    = 32,
  parameter logic [DataWidth-1:0] WordZeroVal  = '0,
  parameter int unsigned          NumReadPorts = 2,
  parameter bit                   BypassEn     = 1'b1,
  localparam int unsigned         ADDR_WIDTH   = RV32E ? 32'd4 : 32'd5,
  localparam int unsigned         NUM_WORDS    = 32'd1 << ADDR_WIDTH
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  // read ports
  input  logic [NumReadPorts-1:0][4:0]           raddr_i,
  output logic [NumReadPorts-1:0][DataWidth-1:0] rdata_o,
  output logic [NumReadPorts-1:0]                rbusy_o,
  // write ports
  input  logic [1:0]                             we_i,
  input  logic [1:0][4:0]                        waddr_i,
  input  logic [1:0][DataWidth-1:0]              wdata_i,
  // reservation handshake
  input  logic                                   rsv_valid_i,
  input  logic [4:0]                             rsv_addr_i,
  output logic                                   rsv_ready_o,
  // status
  output logic [NUM_WORDS-1:0]                   busy_o,
  output logic                                   wr_collision_o
);

  // -------------------------------------------------------------------------
  // Address qualification
  // -------------------------------------------------------------------------
  // An address names real storage only when it is non-zero. In the RV32E
  // configuration it must also stay below 16. Writes, reads and
  // reservations to any other address are neutral.
  function automatic logic addr_valid(input logic [4:0] addr);
    logic ok;
    ok = (addr != 5'd0);
    if (RV32E && addr[4]) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  // -------------------------------------------------------------------------
  // Storage and state
  // -------------------------------------------------------------------------
  // x0 has no flop. Storage starts at index 1.
  logic [DataWidth-1:0]                   mem_r [1:NUM_WORDS-1];
  logic [NUM_WORDS-1:1]                   busy_r;
  logic                                   wr_collision_r;

  logic [1:0]                             we_valid_s;
  logic [NUM_WORDS-1:1]                   we0_dec_s;
  logic [NUM_WORDS-1:1]                   we1_dec_s;
  logic                                   wr_collision_s;

  logic [NUM_WORDS-1:0]                   busy_vec_s;
  logic [NUM_WORDS-1:1]                   busy_set_s;
  logic [NUM_WORDS-1:1]                   busy_clr_s;
  logic                                   rsv_ready_s;
  logic                                   rsv_accept_s;

  logic [NumReadPorts-1:0][DataWidth-1:0] rd_stored_s;
  logic [NumReadPorts-1:0][DataWidth-1:0] rdata_s;
  logic [NumReadPorts-1:0]                rbusy_s;

  // The scoreboard is viewed with a constant-zero bit for x0. This lets
  // every lookup index it directly.
  assign busy_vec_s = {busy_r, 1'b0};

  // -------------------------------------------------------------------------
  // Write decode
  // -------------------------------------------------------------------------
  // Qualify each write port and decode it to a one-hot register select.
  always_comb begin
    we_valid_s[0] = we_i[0] & addr_valid(waddr_i[0]);
    we_valid_s[1] = we_i[1] & addr_valid(waddr_i[1]);
    for (int unsigned r = 32'd1; r < NUM_WORDS; r++) begin
      we0_dec_s[r] = we_valid_s[0] & (waddr_i[0][ADDR_WIDTH-1:0] == ADDR_WIDTH'(r));
      we1_dec_s[r] = we_valid_s[1] & (waddr_i[1][ADDR_WIDTH-1:0] == ADDR_WIDTH'(r));
    end
  end

  // Both ports hit the same register. A valid port-0 address implies the
  // register is non-zero and in range, so port 1 hits the same one.
  assign wr_collision_s = we_valid_s[0] & we_i[1] & (waddr_i[0] == waddr_i[1]);

  // Register update. Port 0 is checked first, so on a collision the port-1
  // data is discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned r = 32'd1; r < NUM_WORDS; r++) begin
        mem_r[r] <= WordZeroVal;
      end
    end else begin
      for (int unsigned r = 32'd1; r < NUM_WORDS; r++) begin
        if (we0_dec_s[r]) begin
          mem_r[r] <= wdata_i[0];
        end else if (we1_dec_s[r]) begin
          mem_r[r] <= wdata_i[1];
        end
      end
    end
  end

  // Collision flag, held for exactly the cycle after the colliding writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_collision_r <= 1'b0;
    end else begin
      wr_collision_r <= wr_collision_s;
    end
  end

  // -------------------------------------------------------------------------
  // Reservation scoreboard
  // -------------------------------------------------------------------------
  // Ready comes only from registered busy and the address, never from
  // rsv_valid_i. A busy register therefore refuses a new owner even in the
  // cycle in which it is being released.
  always_comb begin
    if (rst_i) begin
      rsv_ready_s = 1'b1;
    end else if (!addr_valid(rsv_addr_i)) begin
      rsv_ready_s = 1'b1;
    end else begin
      rsv_ready_s = ~busy_vec_s[rsv_addr_i[ADDR_WIDTH-1:0]];
    end
  end

  // Only an accepted reservation of a real register changes the scoreboard.
  assign rsv_accept_s = rsv_valid_i & rsv_ready_s & addr_valid(rsv_addr_i);

  // Decode the busy set (reservation) and clear (port-1 writeback) requests.
  always_comb begin
    for (int unsigned r = 32'd1; r < NUM_WORDS; r++) begin
      busy_set_s[r] = rsv_accept_s & (rsv_addr_i[ADDR_WIDTH-1:0] == ADDR_WIDTH'(r));
      busy_clr_s[r] = we1_dec_s[r];
    end
  end

  // Scoreboard state. A set beats a clear in the same cycle, so the new
  // owner keeps the register. Port-0 writes never touch busy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r <= '0;
    end else begin
      busy_r <= (busy_r & ~busy_clr_s) | busy_set_s;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  // Per-port lookup of the stored word. No match, which happens only for
  // x0, leaves WordZeroVal.
  always_comb begin
    for (int unsigned p = 32'd0; p < NumReadPorts; p++) begin
      rd_stored_s[p] = WordZeroVal;
      for (int unsigned r = 32'd1; r < NUM_WORDS; r++) begin
        rd_stored_s[p] = (raddr_i[p][ADDR_WIDTH-1:0] == ADDR_WIDTH'(r)) ? mem_r[r]
                                                                         : rd_stored_s[p];
      end
    end
  end

  // Final read data and busy per port.
  //   - Forwarding follows the write priority (port 0 first).
  //   - rbusy_o is registered busy only; a same-cycle clear does not show
  //     up until the next cycle.
  //   - While reset is held, every port reads as if the file were cleared.
  always_comb begin
    for (int unsigned p = 32'd0; p < NumReadPorts; p++) begin
      rdata_s[p] = WordZeroVal;
      rbusy_s[p] = 1'b0;
      if (rst_i || !addr_valid(raddr_i[p])) begin
        rdata_s[p] = WordZeroVal;
        rbusy_s[p] = 1'b0;
      end else begin
        rbusy_s[p] = busy_vec_s[raddr_i[p][ADDR_WIDTH-1:0]];
        if (BypassEn && we_valid_s[0] && (waddr_i[0] == raddr_i[p])) begin
          rdata_s[p] = wdata_i[0];
        end else if (BypassEn && we_valid_s[1] && (waddr_i[1] == raddr_i[p])) begin
          rdata_s[p] = wdata_i[1];
        end else begin
          rdata_s[p] = rd_stored_s[p];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Status outputs read as cleared while reset is held, including the first
  // reset cycle before the flops have been cleared.
  assign rdata_o        = rdata_s;
  assign rbusy_o        = rbusy_s;
  assign rsv_ready_o    = rsv_ready_s;
  assign busy_o         = rst_i ? '0 : busy_vec_s;
  assign wr_collision_o = rst_i ? 1'b0 : wr_collision_r;

endmodule

// File: tb/tb_cve2_register_file_mp.sv
// Bench for cve2_register_file_mp. Three instances share one stimulus stream:
//   - dut_a: default parameters (32 regs, bypass on)
//   - dut_n: bypass off
//   - dut_e: RV32E
// Expected values are queued while stimulus is driven. Each step then drains
// the queue against the sampled outputs.
module tb_cve2_register_file_mp;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [1:0][4:0]     raddr;
  logic [1:0]          we;
  logic [1:0][4:0]     waddr;
  logic [1:0][DW-1:0]  wdata;
  logic                rsv_valid;
  logic [4:0]          rsv_addr;

  logic [1:0][DW-1:0]  a_rdata, n_rdata, e_rdata;
  logic [1:0]          a_rbusy, n_rbusy, e_rbusy;
  logic                a_rdy, n_rdy, e_rdy;
  logic [31:0]         a_busy, n_busy;
  logic [15:0]         e_busy;
  logic                a_coll, n_coll, e_coll;

  cve2_register_file_mp dut_a (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(a_rdata), .rbusy_o(a_rbusy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_valid_i(rsv_valid),
    .rsv_addr_i(rsv_addr), .rsv_ready_o(a_rdy), .busy_o(a_busy), .wr_collision_o(a_coll)
  );

  cve2_register_file_mp #(.BypassEn(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(n_rdata), .rbusy_o(n_rbusy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_valid_i(rsv_valid),
    .rsv_addr_i(rsv_addr), .rsv_ready_o(n_rdy), .busy_o(n_busy), .wr_collision_o(n_coll)
  );

  cve2_register_file_mp #(.RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(e_rdata), .rbusy_o(e_rbusy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_valid_i(rsv_valid),
    .rsv_addr_i(rsv_addr), .rsv_ready_o(e_rdy), .busy_o(e_busy), .wr_collision_o(e_coll)
  );

  // Observation selectors
  localparam int A_RD0 = 0,  A_RD1 = 1,  A_RB0 = 2,  A_RB1 = 3,  A_BUSY = 4, A_RDY = 5;
  localparam int A_COLL = 6, N_RD0 = 7,  N_RD1 = 8,  N_RB = 9,   N_BUSY = 10, N_RDY = 11;
  localparam int N_COLL = 12, E_RD0 = 13, E_RD1 = 14, E_RB = 15, E_BUSY = 16, E_RDY = 17;
  localparam int E_COLL = 18;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      A_RD0:   return a_rdata[0];
      A_RD1:   return a_rdata[1];
      A_RB0:   return {31'd0, a_rbusy[0]};
      A_RB1:   return {31'd0, a_rbusy[1]};
      A_BUSY:  return a_busy;
      A_RDY:   return {31'd0, a_rdy};
      A_COLL:  return {31'd0, a_coll};
      N_RD0:   return n_rdata[0];
      N_RD1:   return n_rdata[1];
      N_RB:    return {30'd0, n_rbusy};
      N_BUSY:  return n_busy;
      N_RDY:   return {31'd0, n_rdy};
      N_COLL:  return {31'd0, n_coll};
      E_RD0:   return e_rdata[0];
      E_RD1:   return e_rdata[1];
      E_RB:    return {30'd0, e_rbusy};
      E_BUSY:  return {16'd0, e_busy};
      E_RDY:   return {31'd0, e_rdy};
      E_COLL:  return {31'd0, e_coll};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic idle();
    rst       = 1'b0;
    we        = 2'b00;
    waddr     = '0;
    wdata     = '0;
    raddr     = '0;
    rsv_valid = 1'b0;
    rsv_addr  = 5'd0;
  endtask

  // Reset is held two cycles with writes, a collision and a reservation
  // presented. Then x0..x31 are swept on all ports.
  task automatic test_reset();
    exp_t e;
    logic [31:0] act;
    for (int s = 0; s < 34; s++) begin
      @(negedge clk);
      idle();
      if (s < 2) begin
        rst = 1'b1;
        we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
        wdata[0] = 32'hA5A5_A5A5; wdata[1] = 32'h5A5A_5A5A;
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        raddr[0] = 5'd5; raddr[1] = 5'd9;
        push("rst_held_rd0", A_RD0, 32'h0);
        push("rst_held_rd1", A_RD1, 32'h0);
        push("rst_held_busy", A_BUSY, 32'h0);
        push("rst_held_rb1", A_RB1, 32'h0);
        push("rst_held_rdy", A_RDY, 32'h1);
        push("rst_held_coll", A_COLL, 32'h0);
        push("rst_held_e_rd0", E_RD0, 32'h0);
      end else begin
        raddr[0] = 5'(s - 2);
        raddr[1] = 5'(33 - s);
        rsv_addr = 5'(s - 2);
        push("rst_rd0", A_RD0, 32'h0);
        push("rst_rd1", A_RD1, 32'h0);
        push("rst_n_rd0", N_RD0, 32'h0);
        push("rst_e_rd1", E_RD1, 32'h0);
        push("rst_busy", A_BUSY, 32'h0);
        push("rst_n_busy", N_BUSY, 32'h0);
        push("rst_e_busy", E_BUSY, 32'h0);
        push("rst_rdy", A_RDY, 32'h1);
        push("rst_n_rdy", N_RDY, 32'h1);
        push("rst_e_rb", E_RB, 32'h0);
        push("rst_n_rb", N_RB, 32'h0);
        push("rst_coll", A_COLL, 32'h0);
        push("rst_n_coll", N_COLL, 32'h0);
        push("rst_e_coll", E_COLL, 32'h0);
      end
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = observe(e.sel);
        n_chk++;
        if (act !== e.exp)
          $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", e.name, s, act, e.exp);
        else
          n_pass++;
      end
    end
  endtask

  // Port 0 writes x5 and port 1 writes x6; both are read in the same cycle.
  task automatic test_write_bypass();
    exp_t e;
    logic [31:0] act;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      idle();
      raddr[0] = 5'd5; raddr[1] = 5'd6;
      case (s)
        0: begin
          we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd6;
          wdata[0] = 32'hDEAD_BEEF; wdata[1] = 32'h1234_5678;
          push("byp_rd0", A_RD0, 32'hDEAD_BEEF);
          push("byp_rd1", A_RD1, 32'h1234_5678);
          push("nobyp_rd0", N_RD0, 32'h0);
          push("nobyp_rd1", N_RD1, 32'h0);
        end
        default: begin
          push("wr_rd0", A_RD0, 32'hDEAD_BEEF);
          push("wr_n_rd0", N_RD0, 32'hDEAD_BEEF);
          push("wr_n_rd1", N_RD1, 32'h1234_5678);
          push("no_coll", A_COLL, 32'h0);
        end
      endcase
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = observe(e.sel);
        n_chk++;
        if (act !== e.exp)
          $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", e.name, s, act, e.exp);
        else
          n_pass++;
      end
    end
  endtask

  // Both write ports hit x7 in the same cycle.
  task automatic test_collision();
    exp_t e;
    logic [31:0] act;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      idle();
      raddr[0] = 5'd7; raddr[1] = 5'd7;
      case (s)
        0: begin
          we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
          wdata[0] = 32'h0000_1111; wdata[1] = 32'h0000_2222;
          push("coll_byp_rd0", A_RD0, 32'h0000_1111);
          push("coll_n_rd0", N_RD0, 32'h0);
          push("coll_before", A_COLL, 32'h0);
        end
        1: begin
          push("coll_rd0", A_RD0, 32'h0000_1111);
          push("coll_n_rd1", N_RD1, 32'h0000_1111);
          push("coll_pulse", A_COLL, 32'h1);
          push("coll_n_pulse", N_COLL, 32'h1);
        end
        default: begin
          push("coll_after", A_COLL, 32'h0);
        end
      endcase
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = observe(e.sel);
        n_chk++;
        if (act !== e.exp)
          $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", e.name, s, act, e.exp);
        else
          n_pass++;
      end
    end
  endtask

  // Writes to x8 on consecutive cycles, alternating ports.
  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] act;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      idle();
      raddr[0] = 5'd8;
      case (s)
        0: begin
          we = 2'b01; waddr[0] = 5'd8; wdata[0] = 32'h1;
          push("b2b_rd0_0", A_RD0, 32'h1);
          push("b2b_n_rd0_0", N_RD0, 32'h0);
        end
        1: begin
          we = 2'b01; waddr[0] = 5'd8; wdata[0] = 32'h2;
          push("b2b_rd0_1", A_RD0, 32'h2);
          push("b2b_n_rd0_1", N_RD0, 32'h1);
        end
        2: begin
          we = 2'b10; waddr[1] = 5'd8; wdata[1] = 32'h3;
          push("b2b_rd0_2", A_RD0, 32'h3);
          push("b2b_n_rd0_2", N_RD0, 32'h2);
        end
        default: begin
          push("b2b_n_rd0_3", N_RD0, 32'h3);
        end
      endcase
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = observe(e.sel);
        n_chk++;
        if (act !== e.exp)
          $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", e.name, s, act, e.exp);
        else
          n_pass++;
      end
    end
  endtask

  // Scoreboard sequence on x10: reserve it, write it on port 0, then
  // release it with a port-1 write.
  task automatic test_scoreboard();
    exp_t e;
    logic [31:0] act;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      idle();
      raddr[0] = 5'd10; rsv_addr = 5'd10;
      case (s)
        0: begin
          rsv_valid = 1'b1;
          push("sb_rdy_free", A_RDY, 32'h1);
          push("sb_rb_free", A_RB0, 32'h0);
          push("sb_busy_free", A_BUSY, 32'h0);
        end
        1: begin
          push("sb_busy_set", A_BUSY, 32'h0000_0400);
          push("sb_e_busy_set", E_BUSY, 32'h0000_0400);
          push("sb_rdy_busy", A_RDY, 32'h0);
          push("sb_rb_busy", A_RB0, 32'h1);
        end
        2: begin
          we = 2'b01; waddr[0] = 5'd10; wdata[0] = 32'h0000_AAAA;
          push("sb_p0_rb", A_RB0, 32'h1);
          push("sb_p0_rd", A_RD0, 32'h0000_AAAA);
          push("sb_p0_rdy", A_RDY, 32'h0);
        end
        3: begin
          push("sb_p0_busy", A_BUSY, 32'h0000_0400);
          push("sb_p0_rd_reg", A_RD0, 32'h0000_AAAA);
        end
        4: begin
          we = 2'b10; waddr[1] = 5'd10; wdata[1] = 32'h0000_CAFE;
          rsv_valid = 1'b1;
          push("sb_p1_byp", A_RD0, 32'h0000_CAFE);
          push("sb_p1_rb", A_RB0, 32'h1);
          push("sb_p1_rdy", A_RDY, 32'h0);
        end
        default: begin
          push("sb_clr_busy", A_BUSY, 32'h0);
          push("sb_clr_rd", A_RD0, 32'h0000_CAFE);
          push("sb_clr_n_rd", N_RD0, 32'h0000_CAFE);
          push("sb_clr_rb", A_RB0, 32'h0);
          push("sb_clr_rdy", A_RDY, 32'h1);
        end
      endcase
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = observe(e.sel);
        n_chk++;
        if (act !== e.exp)
          $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", e.name, s, act, e.exp);
        else
          n_pass++;
      end
    end
  endtask

  // x0 accesses, plus out-of-range accesses on the RV32E instance.
  task automatic test_x0_rv32e();
    exp_t e;
    logic [31:0] act;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      idle();
      case (s)
        0: begin
          we = 2'b11; wdata[0] = 32'h55; wdata[1] = 32'h66;
          rsv_valid = 1'b1; rsv_addr = 5'd0;
          push("x0_rd0", A_RD0, 32'h0);
          push("x0_rd1", A_RD1, 32'h0);
          push("x0_rdy", A_RDY, 32'h1);
        end
        1: begin
          push("x0_busy", A_BUSY, 32'h0);
          push("x0_rd0_after", A_RD0, 32'h0);
          push("x0_no_coll", A_COLL, 32'h0);
        end
        2: begin
          we = 2'b01; waddr[0] = 5'd20; wdata[0] = 32'h77;
          rsv_valid = 1'b1; rsv_addr = 5'd20;
          raddr[0] = 5'd20; raddr[1] = 5'd4;
          push("e_oor_byp", E_RD0, 32'h0);
          push("e_oor_rb", E_RB, 32'h0);
          push("e_oor_rdy", E_RDY, 32'h1);
          push("a_x20_byp", A_RD0, 32'h77);
        end
        3: begin
          raddr[0] = 5'd20; raddr[1] = 5'd4;
          push("e_oor_rd", E_RD0, 32'h0);
          push("e_no_alias", E_RD1, 32'h0);
          push("e_oor_busy", E_BUSY, 32'h0);
          push("a_x20_rd", A_RD0, 32'h77);
          push("a_x20_busy", A_BUSY, 32'h0010_0000);
        end
        4: begin
          we = 2'b10; waddr[1] = 5'd20; wdata[1] = 32'h78;
          raddr[0] = 5'd20;
          push("a_x20_p1_byp", A_RD0, 32'h78);
          push("e_oor_p1", E_RD0, 32'h0);
        end
        default: begin
          raddr[0] = 5'd20;
          push("a_x20_clr", A_BUSY, 32'h0);
          push("a_x20_p1_rd", A_RD0, 32'h78);
          push("e_oor_p1_rd", E_RD0, 32'h0);
        end
      endcase
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = observe(e.sel);
        n_chk++;
        if (act !== e.exp)
          $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", e.name, s, act, e.exp);
        else
          n_pass++;
      end
    end
  endtask

  // Reserve x3, then reset while it is outstanding; the port-1 write that
  // follows lands with busy already clear.
  task automatic test_reset_mid_rsv();
    exp_t e;
    logic [31:0] act;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      idle();
      rsv_addr = 5'd3;
      case (s)
        0: begin
          rsv_valid = 1'b1;
          push("mr_rdy", A_RDY, 32'h1);
        end
        1: begin
          push("mr_busy_set", A_BUSY, 32'h0000_0008);
        end
        2: begin
          rst = 1'b1;
          raddr[0] = 5'd5; raddr[1] = 5'd3;
          push("mr_rst_busy", A_BUSY, 32'h0);
          push("mr_rst_rdy", A_RDY, 32'h1);
          push("mr_rst_rd", A_RD0, 32'h0);
          push("mr_rst_rb", A_RB1, 32'h0);
          push("mr_rst_coll", A_COLL, 32'h0);
        end
        3: begin
          we = 2'b10; waddr[1] = 5'd3; wdata[1] = 32'h9;
          raddr[0] = 5'd3;
          push("mr_p1_busy", A_BUSY, 32'h0);
          push("mr_p1_byp", A_RD0, 32'h9);
          push("mr_p1_rb", A_RB0, 32'h0);
          push("mr_p1_rdy", A_RDY, 32'h1);
        end
        default: begin
          raddr[0] = 5'd3; raddr[1] = 5'd5;
          push("mr_rd", A_RD0, 32'h9);
          push("mr_n_rd", N_RD0, 32'h9);
          push("mr_busy", A_BUSY, 32'h0);
          push("mr_x5_cleared", A_RD1, 32'h0);
        end
      endcase
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = observe(e.sel);
        n_chk++;
        if (act !== e.exp)
          $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", e.name, s, act, e.exp);
        else
          n_pass++;
      end
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_write_bypass();
    test_collision();
    test_back_to_back();
    test_scoreboard();
    test_x0_rv32e();
    test_reset_mid_rsv();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
